mem_port_arbiter: RTL and testbench

Shares the single unified memory port of sagittarius_top between the instruction-fetch stage (I side) and the load/store stage (D side). A small FSM grants one requester at a time and holds the memory-side signals stable until the memory acknowledges. It returns read data and a one-cycle ack to the winner, and drives stall_req to the pipeline control unit while any request is outstanding.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to build the timeout counter.
module mem_port_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic [DW-1:0]   i_rdata,
   output logic            i_ack,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_sel,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic [DW-1:0]   d_rdata,
   output logic            d_ack,
   output logic            m_req,
   output logic            m_we,
   output logic [DW/8-1:0] m_sel,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   input  logic [DW-1:0]   m_rdata,
   input  logic            m_ack,
   output logic            stall_req,
   output logic            err
);

   typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, DONE} state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              m_req_q, m_req_d;
   logic              m_we_q, m_we_d;
   logic [DW/8-1:0]   m_sel_q, m_sel_d;
   logic [AW-1:0]     m_addr_q, m_addr_d;
   logic [DW-1:0]     m_wdata_q, m_wdata_d;
   logic [DW-1:0]     i_rdata_q, i_rdata_d;
   logic [DW-1:0]     d_rdata_q, d_rdata_d;
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              expire;
   assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign err    = err_q;
`else
   logic [31:0]       unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign err            = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_sel_d   = m_sel_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            // On contention D wins unless it was served last
            if (d_req && (!i_req || !last_d_q)) begin
               state_d   = GNT_D;
               last_d_d  = 1'b1;
               m_req_d   = 1'b1;
               m_we_d    = d_we;
               m_sel_d   = d_sel;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
            end else if (i_req) begin
               state_d   = GNT_I;
               last_d_d  = 1'b0;
               m_req_d   = 1'b1;
               m_we_d    = 1'b0;
               m_sel_d   = '1;
               m_addr_d  = i_addr;
               m_wdata_d = '0;
            end
         end
         GNT_D, GNT_I: begin
            if (m_ack) begin
               m_req_d = 1'b0;
               state_d = DONE;
               if (state_q == GNT_D) begin
                  d_rdata_d = m_rdata;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = m_rdata;
                  i_ack_d   = 1'b1;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (expire) begin
               m_req_d = 1'b0;
               state_d = DONE;
               err_d   = 1'b1;
               if (state_q == GNT_D) begin
                  d_rdata_d = '0;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = '0;
                  i_ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_d_q  <= 1'b0;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_sel_q   <= '0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_sel_q   <= m_sel_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign m_req     = m_req_q;
   assign m_we      = m_we_q;
   assign m_sel     = m_sel_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign stall_req = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic          clk;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [SW-1:0] d_sel;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          m_req;
   logic          m_we;
   logic [SW-1:0] m_sel;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          stall_req;
   logic          err;

   int n_cmp;
   int n_bad;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
      .stall_req(stall_req), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_sel   = '0;
      d_addr  = '0;
      d_wdata = '0;
      m_ack   = 1'b0;
      m_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst     = 1'b1;
      d_req   = 1'b1;
      m_ack   = 1'b1;
      m_rdata = '1;
      step();
      step();
      n_cmp++;
      if ({m_req, m_we, m_sel, m_addr, m_wdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_mem: got %h want 0",
                  {m_req, m_we, m_sel, m_addr, m_wdata});
      end
      n_cmp++;
      if ({i_ack, d_ack, err} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ack: got %b want 000", {i_ack, d_ack, err});
      end
      n_cmp++;
      if ({i_rdata, d_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata});
      end
      idle_inputs();
      step();
      rst = 1'b0;
   endtask

   task automatic test_read_zero_wait();
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_sel   = '1;
      d_addr  = 32'h100;
      m_ack   = 1'b1;
      m_rdata = 32'hCAFEF00D;
      #1;
      n_cmp++;
      if (stall_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rd_stall_pre: got %b want 1", stall_req);
      end
      step();
      n_cmp++;
      if ({m_req, m_we, m_addr, d_ack} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
         n_bad++;
         $display("FAIL rd_grant: got %h want %h",
                  {m_req, m_we, m_addr, d_ack}, {1'b1, 1'b0, 32'h100, 1'b0});
      end
      step();
      n_cmp++;
      if ({d_ack, i_ack, m_req, stall_req} !== 4'b1000) begin
         n_bad++;
         $display("FAIL rd_ack: got %b want 1000",
                  {d_ack, i_ack, m_req, stall_req});
      end
      n_cmp++;
      if (d_rdata !== 32'hCAFEF00D) begin
         n_bad++;
         $display("FAIL rd_data: got %h want cafef00d", d_rdata);
      end
      d_req   = 1'b0;
      m_ack   = 1'b0;
      m_rdata = '0;
      step();
      n_cmp++;
      if ({d_ack, d_rdata} !== {1'b0, 32'hCAFEF00D}) begin
         n_bad++;
         $display("FAIL rd_hold: got %h want %h",
                  {d_ack, d_rdata}, {1'b0, 32'hCAFEF00D});
      end
      step();
   endtask

   task automatic test_alternation();
      logic          exp_d;
      logic [DW-1:0] sent;
      int            acks;
      do_reset();
      i_req  = 1'b1;
      i_addr = 32'h2000;
      d_req  = 1'b1;
      d_addr = 32'h3000;
      d_we   = 1'b0;
      d_sel  = '1;
      m_ack  = 1'b1;
      m_rdata = $urandom;
      exp_d  = 1'b1;
      acks   = 0;
      for (int k = 0; k < 12; k++) begin
         sent = m_rdata;
         step();
         if (m_req) begin
            n_cmp++;
            if (m_addr !== (exp_d ? 32'h3000 : 32'h2000)) begin
               n_bad++;
               $display("FAIL alt_addr: got %h want %h", m_addr,
                        exp_d ? 32'h3000 : 32'h2000);
            end
         end
         if (i_ack || d_ack) begin
            n_cmp++;
            if ({d_ack, i_ack} !== {exp_d, ~exp_d}) begin
               n_bad++;
               $display("FAIL alt_order: got %b want %b",
                        {d_ack, i_ack}, {exp_d, ~exp_d});
            end
            n_cmp++;
            if ((exp_d ? d_rdata : i_rdata) !== sent) begin
               n_bad++;
               $display("FAIL alt_rdata: got %h want %h",
                        exp_d ? d_rdata : i_rdata, sent);
            end
            exp_d = ~exp_d;
            acks++;
         end
         m_rdata = $urandom;
      end
      n_cmp++;
      if (acks != 4) begin
         n_bad++;
         $display("FAIL alt_count: got %0d want 4", acks);
      end
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_write_wait();
      logic [69:0] snap;
      int          nd;
      int          ni;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_sel   = 4'b0011;
      d_wdata = 32'h12345678;
      d_addr  = 32'h0000_0A00;
      m_ack   = 1'b0;
      step();
      snap = {1'b1, 1'b1, 4'b0011, 32'h0000_0A00, 32'h12345678};
      n_cmp++;
      if ({m_req, m_we, m_sel, m_addr, m_wdata} !== snap) begin
         n_bad++;
         $display("FAIL wr_grant: got %h want %h",
                  {m_req, m_we, m_sel, m_addr, m_wdata}, snap);
      end
      nd = 0;
      ni = 0;
      for (int k = 0; k < 4; k++) begin
         d_addr  = $urandom;
         d_wdata = $urandom;
         step();
         n_cmp++;
         if ({m_req, m_we, m_sel, m_addr, m_wdata} !== snap) begin
            n_bad++;
            $display("FAIL wr_stable: got %h want %h",
                     {m_req, m_we, m_sel, m_addr, m_wdata}, snap);
         end
         nd += int'(d_ack);
         ni += int'(i_ack);
      end
      m_ack   = 1'b1;
      m_rdata = 32'h0F0F_1111;
      step();
      n_cmp++;
      if ({d_ack, m_req, d_rdata} !== {1'b1, 1'b0, 32'h0F0F_1111}) begin
         n_bad++;
         $display("FAIL wr_ack: got %h want %h",
                  {d_ack, m_req, d_rdata}, {1'b1, 1'b0, 32'h0F0F_1111});
      end
      nd += int'(d_ack);
      ni += int'(i_ack);
      d_req = 1'b0;
      m_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         nd += int'(d_ack);
         ni += int'(i_ack);
      end
      n_cmp++;
      if (nd != 1) begin
         n_bad++;
         $display("FAIL wr_dack_count: got %0d want 1", nd);
      end
      n_cmp++;
      if (ni != 0) begin
         n_bad++;
         $display("FAIL wr_iack_count: got %0d want 0", ni);
      end
   endtask

   task automatic test_reset_mid();
      i_req   = 1'b1;
      i_addr  = 32'h40;
      m_ack   = 1'b1;
      m_rdata = 32'h5A5A_1234;
      step();
      step();
      n_cmp++;
      if ({i_ack, i_rdata} !== {1'b1, 32'h5A5A_1234}) begin
         n_bad++;
         $display("FAIL rm_pre: got %h want %h",
                  {i_ack, i_rdata}, {1'b1, 32'h5A5A_1234});
      end
      i_req = 1'b0;
      m_ack = 1'b0;
      step();
      step();
      i_req  = 1'b1;
      i_addr = 32'h80;
      step();
      n_cmp++;
      if (m_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rm_grant: got %b want 1", m_req);
      end
      step();
      step();
      rst = 1'b1;
      step();
      n_cmp++;
      if ({m_req, i_ack, d_ack, err, m_addr, i_rdata} !== '0) begin
         n_bad++;
         $display("FAIL rm_reset: got %h want 0",
                  {m_req, i_ack, d_ack, err, m_addr, i_rdata});
      end
      rst     = 1'b0;
      m_ack   = 1'b1;
      m_rdata = 32'h0BAD_BEEF;
      step();
      n_cmp++;
      if ({m_req, m_we, m_sel, m_addr} !== {1'b1, 1'b0, 4'hF, 32'h80}) begin
         n_bad++;
         $display("FAIL rm_regrant: got %h want %h",
                  {m_req, m_we, m_sel, m_addr}, {1'b1, 1'b0, 4'hF, 32'h80});
      end
      step();
      n_cmp++;
      if ({i_ack, i_rdata} !== {1'b1, 32'h0BAD_BEEF}) begin
         n_bad++;
         $display("FAIL rm_ack: got %h want %h",
                  {i_ack, i_rdata}, {1'b1, 32'h0BAD_BEEF});
      end
      idle_inputs();
      step();
      step();
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      for (int run = 0; run < 2; run++) begin
         i_req  = 1'b1;
         i_addr = 32'h44;
         m_ack  = 1'b0;
         step();
         for (int k = 0; k < 7; k++) begin
            step();
            n_cmp++;
            if ({m_req, err, i_ack} !== 3'b100) begin
               n_bad++;
               $display("FAIL to_wait: got %b want 100", {m_req, err, i_ack});
            end
         end
         if (run == 1) begin
            m_ack   = 1'b1;
            m_rdata = 32'h600D_F00D;
         end
         step();
         n_cmp++;
         if (run == 0) begin
            if ({m_req, err, i_ack, i_rdata} !== {3'b011, 32'h0}) begin
               n_bad++;
               $display("FAIL to_expire: got %h want %h",
                        {m_req, err, i_ack, i_rdata}, {3'b011, 32'h0});
            end
         end else begin
            if ({m_req, err, i_ack, i_rdata} !== {3'b001, 32'h600D_F00D}) begin
               n_bad++;
               $display("FAIL to_ack_wins: got %h want %h",
                        {m_req, err, i_ack, i_rdata}, {3'b001, 32'h600D_F00D});
            end
         end
         i_req = 1'b0;
         m_ack = 1'b0;
         step();
         n_cmp++;
         if ({err, i_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL to_pulse: got %b want 00", {err, i_ack});
         end
         step();
      end
   endtask
`endif

   task automatic test_random();
      logic          busy, on_d, lastd, new_gnt, ei, ed;
      int            free_at, wl, n_ack;
      logic          s_ir, s_dr, s_dwe, s_ma;
      logic [SW-1:0] s_dsel;
      logic [AW-1:0] s_ia, s_da;
      logic [DW-1:0] s_dw, s_mr;
      logic [AW+DW+SW:0] exp_m;
      logic [DW-1:0] exp_ir, exp_dr;
      do_reset();
      busy = 0; on_d = 0; lastd = 0; free_at = 0; wl = 0; n_ack = 0;
      exp_ir = '0; exp_dr = '0; exp_m = '0;
      for (int e = 0; e < 3000; e++) begin
         s_ir = i_req; s_ia = i_addr;
         s_dr = d_req; s_dwe = d_we; s_dsel = d_sel;
         s_da = d_addr; s_dw = d_wdata;
         s_ma = m_ack; s_mr = m_rdata;
         step();
         ei = 0; ed = 0; new_gnt = 0;
         if (busy) begin
            if (s_ma) begin
               busy = 0;
               free_at = e + 2;
               n_ack++;
               if (on_d) begin ed = 1; exp_dr = s_mr; end
               else begin ei = 1; exp_ir = s_mr; end
            end
         end else if (e >= free_at && (s_ir || s_dr)) begin
            on_d = s_dr && (!s_ir || !lastd);
            lastd = on_d;
            busy = 1;
            new_gnt = 1;
            if (on_d) exp_m = {s_dwe, s_dsel, s_da, s_dw};
            else exp_m = {1'b0, {SW{1'b1}}, s_ia, {DW{1'b0}}};
         end
         n_cmp++;
         if (m_req !== busy) begin
            n_bad++;
            $display("FAIL rnd_mreq: cycle %0d got %b want %b", e, m_req, busy);
         end
         if (busy) begin
            n_cmp++;
            if (on_d) begin
               if ({m_we, m_sel, m_addr, m_wdata} !== exp_m) begin
                  n_bad++;
                  $display("FAIL rnd_dfields: cycle %0d got %h want %h", e,
                           {m_we, m_sel, m_addr, m_wdata}, exp_m);
               end
            end else begin
               if ({m_we, m_sel, m_addr} !== exp_m[AW+DW+SW:DW]) begin
                  n_bad++;
                  $display("FAIL rnd_ifields: cycle %0d got %h want %h", e,
                           {m_we, m_sel, m_addr}, exp_m[AW+DW+SW:DW]);
               end
            end
         end
         n_cmp++;
         if ({i_ack, d_ack, err} !== {ei, ed, 1'b0}) begin
            n_bad++;
            $display("FAIL rnd_ack: cycle %0d got %b want %b", e,
                     {i_ack, d_ack, err}, {ei, ed, 1'b0});
         end
         n_cmp++;
         if ({i_rdata, d_rdata} !== {exp_ir, exp_dr}) begin
            n_bad++;
            $display("FAIL rnd_rdata: cycle %0d got %h want %h", e,
                     {i_rdata, d_rdata}, {exp_ir, exp_dr});
         end
         if (ei) begin
            i_req = ($urandom_range(0, 1) == 1);
            i_addr = $urandom;
         end else if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1'b1;
            i_addr = $urandom;
         end
         if (ed || (!d_req && $urandom_range(0, 2) == 0)) begin
            d_req = ed ? ($urandom_range(0, 1) == 1) : 1'b1;
            d_we = ($urandom_range(0, 1) == 1);
            d_sel = SW'($urandom);
            d_addr = $urandom;
            d_wdata = $urandom;
         end
         if (busy) begin
            if (new_gnt) wl = $urandom_range(0, 3);
            if (wl == 0) m_ack = 1'b1;
            else begin
               m_ack = 1'b0;
               wl--;
            end
         end else begin
            m_ack = ($urandom_range(0, 3) == 0);
         end
         m_rdata = $urandom;
         #1;
         n_cmp++;
         if (stall_req !== ((i_req && !ei) || (d_req && !ed))) begin
            n_bad++;
            $display("FAIL rnd_stall: cycle %0d got %b want %b", e, stall_req,
                     (i_req && !ei) || (d_req && !ed));
         end
      end
      n_cmp++;
      if (n_ack < 100) begin
         n_bad++;
         $display("FAIL rnd_progress: got %0d acks want >= 100", n_ack);
      end
      idle_inputs();
      step();
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_read_zero_wait();
      test_alternation();
      test_write_wait();
      test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
